// File: rtl/nic_vc_fifo.sv
// rtl/nic_vc_fifo.sv - PE/router network interface with DEPTH-deep FIFOs per direction
//
// Ports:
//   clk, reset (async, active-low)
//   PE side    : nicEn, nicWrEN, addr[1:0], d_in, d_out (registered)
//   Router in  : net_si, net_ri, net_di
//   Router out : net_so, net_ro, net_do, net_polarity
// Register map: 00 input data (pop), 01 input status, 10 output data (push), 11 output status.
// Status word: {.., err, count[CW-1:0], flag}; flag is in_nonempty / out_full.
// Optional feature: define NIC_ERR_STATUS_EN for sticky rd_err / wr_err flags
// reported at status bit CW+1 and cleared by reading the matching status word.
module nic_vc_fifo #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 4,
    parameter int VC_BIT     = DATA_WIDTH - 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  nicEn,
    input  logic                  nicWrEN,
    input  logic [1:0]            addr,
    input  logic [DATA_WIDTH-1:0] d_in,
    output logic [DATA_WIDTH-1:0] d_out,
    input  logic                  net_si,
    output logic                  net_ri,
    input  logic [DATA_WIDTH-1:0] net_di,
    output logic                  net_so,
    input  logic                  net_ro,
    output logic [DATA_WIDTH-1:0] net_do,
    input  logic                  net_polarity
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DATA_WIDTH-1:0] r_in_mem  [DEPTH];
    logic [DATA_WIDTH-1:0] r_out_mem [DEPTH];
    logic [PW-1:0]         r_in_wp, r_in_rp, r_out_wp, r_out_rp;
    logic [CW-1:0]         r_in_cnt, r_out_cnt;
    logic [DATA_WIDTH-1:0] r_d_out;

    logic                  w_in_full, w_in_nonempty, w_out_full, w_out_nonempty;
    logic                  w_pe_rd, w_pe_wr;
    logic                  w_in_push, w_in_pop, w_out_push, w_out_pop;
    logic [DATA_WIDTH-1:0] w_in_head, w_out_head;
    logic [DATA_WIDTH-1:0] w_in_status, w_out_status;

    assign w_in_full      = (r_in_cnt == CW'(DEPTH));
    assign w_in_nonempty  = (r_in_cnt != '0);
    assign w_out_full     = (r_out_cnt == CW'(DEPTH));
    assign w_out_nonempty = (r_out_cnt != '0);

    assign w_in_head  = r_in_mem[r_in_rp];
    assign w_out_head = r_out_mem[r_out_rp];

    assign w_pe_rd = nicEn & ~nicWrEN;
    assign w_pe_wr = nicEn & nicWrEN;

    // All full/empty decisions use pre-edge state, so a push into a full
    // FIFO is dropped even when a pop frees a slot on the same edge.
    assign w_in_push  = net_si & ~w_in_full;
    assign w_in_pop   = w_pe_rd & (addr == 2'b00) & w_in_nonempty;
    assign w_out_push = w_pe_wr & (addr == 2'b10) & ~w_out_full;
    assign w_out_pop  = net_so & net_ro;

    assign net_ri = ~w_in_full;
    assign net_do = w_out_nonempty ? w_out_head : '0;
    // Only the head is eligible; a VC mismatch stalls the whole queue.
    assign net_so = w_out_nonempty & (w_out_head[VC_BIT] == net_polarity);
    assign d_out  = r_d_out;

`ifdef NIC_ERR_STATUS_EN
    logic r_rd_err, r_wr_err;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd_err <= 1'b0;
            r_wr_err <= 1'b0;
        end else begin
            if (w_pe_rd && addr == 2'b00 && !w_in_nonempty)
                r_rd_err <= 1'b1;
            else if (w_pe_rd && addr == 2'b01)
                r_rd_err <= 1'b0;
            if (w_pe_wr && addr == 2'b10 && w_out_full)
                r_wr_err <= 1'b1;
            else if (w_pe_rd && addr == 2'b11)
                r_wr_err <= 1'b0;
        end
    end
`endif

    always_comb begin
        w_in_status          = '0;
        w_in_status[CW:1]    = r_in_cnt;
        w_in_status[0]       = w_in_nonempty;
        w_out_status         = '0;
        w_out_status[CW:1]   = r_out_cnt;
        w_out_status[0]      = w_out_full;
`ifdef NIC_ERR_STATUS_EN
        w_in_status[CW+1]    = r_rd_err;
        w_out_status[CW+1]   = r_wr_err;
`endif
    end

    // Storage arrays carry no reset: occupancy is governed by the counts.
    always_ff @(posedge clk) begin
        if (w_in_push)
            r_in_mem[r_in_wp] <= net_di;
        if (w_out_push)
            r_out_mem[r_out_wp] <= d_in;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_in_wp   <= '0;
            r_in_rp   <= '0;
            r_in_cnt  <= '0;
            r_out_wp  <= '0;
            r_out_rp  <= '0;
            r_out_cnt <= '0;
        end else begin
            if (w_in_push)
                r_in_wp <= r_in_wp + 1'b1;
            if (w_in_pop)
                r_in_rp <= r_in_rp + 1'b1;
            case ({w_in_push, w_in_pop})
                2'b10:   r_in_cnt <= r_in_cnt + 1'b1;
                2'b01:   r_in_cnt <= r_in_cnt - 1'b1;
                default: r_in_cnt <= r_in_cnt;
            endcase

            if (w_out_push)
                r_out_wp <= r_out_wp + 1'b1;
            if (w_out_pop)
                r_out_rp <= r_out_rp + 1'b1;
            case ({w_out_push, w_out_pop})
                2'b10:   r_out_cnt <= r_out_cnt + 1'b1;
                2'b01:   r_out_cnt <= r_out_cnt - 1'b1;
                default: r_out_cnt <= r_out_cnt;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_d_out <= '0;
        end else if (w_pe_rd) begin
            case (addr)
                2'b00:   r_d_out <= w_in_nonempty ? w_in_head : '0;
                2'b01:   r_d_out <= w_in_status;
                2'b11:   r_d_out <= w_out_status;
                default: r_d_out <= '0;
            endcase
        end
    end

endmodule

// File: doc/nic_vc_fifo.md
Name: nic_vc_fifo

Overview:
- Parametrised next-generation network interface controller between one processing element (PE) and one router port.
- Replaces single-entry input/output buffers with DEPTH-deep FIFOs per direction and a generalised data width.
- Adds occupancy-count status words.
- Keeps the PE register map (addr 00/01/10/11) and the router handshake with polarity-gated send (net_si/net_ri, net_so/net_ro, net_polarity).

Parameters:
- DATA_WIDTH, 64, packet width in bits; minimum 16.
- DEPTH, 4, entries per FIFO; power of two, at least 2.
- VC_BIT, DATA_WIDTH-1, packet bit carrying the virtual-channel (even/odd) tag.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- nicEn  in  1  PE access enable.
- nicWrEN  in  1  PE write (1) / read (0).
- addr  in  2  register select: 00 input data, 01 input status, 10 output data, 11 output status.
- d_in  in  DATA_WIDTH  PE write data.
- d_out  out  DATA_WIDTH  PE read data, registered.
- net_si  in  1  router has a valid packet on net_di.
- net_ri  out  1  NIC can accept a packet.
- net_di  in  DATA_WIDTH  packet from router.
- net_so  out  1  NIC offers a packet on net_do.
- net_ro  in  1  router can accept a packet.
- net_do  out  DATA_WIDTH  packet to router.
- net_polarity  in  1  current router polarity phase.

Behaviour:
- Reset (reset=0, asynchronous): both FIFOs empty, pointers and counts 0, d_out=0, net_ri=1, net_so=0, net_do=0.
- Counts are CW=$clog2(DEPTH)+1 bits wide; pointers wrap modulo DEPTH.
- Router to NIC:
  - net_ri = ~in_full, combinational from registered state.
  - Push into the input FIFO on the rising edge when net_si && net_ri.
  - net_si while full is ignored; the packet is not stored.
- NIC to router:
  - net_do = output FIFO head, combinational; 0 when empty.
  - net_so = out_nonempty && (head[VC_BIT] == net_polarity).
  - Pop on the rising edge when net_so && net_ro.
  - A head whose VC bit mismatches waits; later entries are not reordered.
- PE reads (nicEn=1, nicWrEN=0), 1-cycle latency; d_out updates on the edge:
  - addr 00, input FIFO non-empty: d_out = head, head popped.
  - addr 00, input FIFO empty: d_out = 0, no pop.
  - addr 01: d_out = {zeros, in_count[CW-1:0], in_nonempty}.
  - addr 11: d_out = {zeros, out_count[CW-1:0], out_full}.
  - addr 10 read: d_out = 0.
- PE writes (nicEn=1, nicWrEN=1):
  - addr 10, output FIFO not full: push d_in.
  - addr 10, output FIFO full: write dropped.
  - Writes to other addresses are ignored; d_out holds.
- nicEn=0: d_out holds its value; no PE side effects.
- Simultaneous events:
  - Full flags are evaluated on pre-edge state. A push into a full FIFO is dropped even if a pop occurs on the same edge.
  - Push and pop on a non-empty, non-full FIFO in the same cycle leave the count unchanged.
  - A pop attempt on an empty FIFO does nothing; a simultaneous push still succeeds.
- reset asserted mid-transfer: all FIFO contents are discarded immediately. No packet is presented after reset release until new data arrives.

Optional Feature:
- Macro: NIC_ERR_STATUS_EN.
- Defined:
  - Adds two sticky error flags: rd_err (PE read of addr 00 while empty) and wr_err (PE write of addr 10 while full).
  - Flags are reported in status words as bit CW+1: input status carries rd_err, output status carries wr_err.
  - Reading the corresponding status address clears the flag on the same edge. The returned value shows the pre-clear flag.
  - Both flags reset to 0.
- Undefined: bit CW+1 of both status words reads 0; no error state exists.

Test Plan:
- Reset, then PE reads addr 01 and addr 00 -> d_out=0 both cycles, net_ri=1, net_so=0.
- net_si=1 with net_di=64'h0EDCBA9876543210 for one cycle, then read 01 -> {count=1, nonempty=1}. Read 00 -> d_out=64'h0EDCBA9876543210. Read 01 -> 0.
- Push DEPTH (4) router packets 1..4 -> net_ri=0 after the 4th. A 5th net_si is not stored. PE reads 00 four times -> 1,2,3,4 in order, wrap-around correct.
- PE writes 64'h0BCD1234567890FF (VC bit 0) to addr 10 with net_ro=1, net_polarity=1 -> net_so=0. Set net_polarity=0 -> net_so=1, pop next edge, out_count=0.
- Fill output FIFO with net_ro=0, then write 64'hDEADBEEF12345678 -> dropped. Addr 11 reads {count=4, full=1}; with NIC_ERR_STATUS_EN, wr_err bit=1, then 0 on next status read.
- Input FIFO full, net_si=1 and PE addr 00 read in the same cycle -> pop happens, push dropped, count=DEPTH-1.
